// File: rtl/note_player_if.sv
// Note handshake between song_reader (master) and note_player (slave).
// song_reader strobes a note/duration pair; note_player answers with note_done.
interface note_player_if;
    logic       load_new_note;
    logic [5:0] note_to_load;
    logic [5:0] duration_to_load;
    logic       note_done;

    modport master (
        output load_new_note,
        output note_to_load,
        output duration_to_load,
        input  note_done
    );

    modport slave (
        input  load_new_note,
        input  note_to_load,
        input  duration_to_load,
        output note_done
    );
endinterface

// File: rtl/note_player.sv
// note_player: plays one note at a time for song_reader.
// A phase accumulator advances by the note's frequency step on every sample tick
// while a beat counter runs the duration down; note_done pulses when it expires.
// The step word comes from frequency_rom, addressed by the latched note number.
module note_player #(
    parameter int PHASE_W = 22,
    parameter int STEP_W  = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play_enable,
    input  logic               beat,
    input  logic               generate_next_sample,
    note_player_if.slave       song,
    output logic [5:0]         rom_addr,
    input  logic [STEP_W-1:0]  rom_step,
    output logic [PHASE_W-1:0] phase,
    output logic               new_phase_ready,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [PHASE_W-1:0] step;
    logic [5:0]         remaining;
    logic               note_done;
    logic               beat_take;
    logic               sample_take;

    assign song.note_done = note_done;

    // Ticks only count while actively playing; remaining>=1 keeps the counter from underflowing.
    assign beat_take   = (state == PLAY) && play_enable && beat && (remaining != 6'd0);
    assign sample_take = (state == PLAY) && play_enable && generate_next_sample;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, regardless of statement order.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: IDLE -> LOAD -> PLAY -> DONE -> IDLE.
    always_comb begin
        // NOTE: default assigned first so no path leaves next_state unassigned,
        // which would otherwise infer a latch.
        next_state = state;
        case (state)
            IDLE: if (song.load_new_note) next_state = LOAD;
            LOAD: next_state = (remaining == 6'd0) ? DONE : PLAY;
            PLAY: if (beat_take && (remaining == 6'd1)) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs; flags are decoded from next_state so they
    // line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rom_addr        <= 6'd0;
            remaining       <= 6'd0;
            step            <= '0;
            phase           <= '0;
            new_phase_ready <= 1'b0;
            busy            <= 1'b0;
            note_done       <= 1'b0;
        end else begin
            new_phase_ready <= sample_take;
            busy            <= (next_state == LOAD) || (next_state == PLAY);
            note_done       <= (next_state == DONE);

            if ((state == IDLE) && song.load_new_note) begin
                rom_addr  <= song.note_to_load;
                remaining <= song.duration_to_load;
                phase     <= '0;
            end

            // The ROM data for the just-latched address is valid during LOAD.
            // Note 0 is a rest: force a zero step so the phase never moves.
            if (state == LOAD) begin
                step <= (rom_addr == 6'd0) ? '0 : PHASE_W'(rom_step);
            end

            if (beat_take) begin
                remaining <= remaining - 6'd1;
            end

            if (sample_take) begin
                phase <= phase + step;
            end
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Directed testbench for note_player. Stimulus is driven 1 time unit after each
// rising edge and outputs are inspected at that same point, after the registers settle.
module tb_note_player;

    logic        clk;
    logic        reset;
    logic        play_enable;
    logic        beat;
    logic        generate_next_sample;
    logic [5:0]  rom_addr;
    logic [19:0] rom_step;
    logic [21:0] phase;
    logic        new_phase_ready;
    logic        busy;

    logic [19:0] rom_mem [64];
    int          checks;
    int          errors;
    int          done_count;

    note_player_if song ();

    note_player #(.PHASE_W(22), .STEP_W(20)) dut (
        .clk                  (clk),
        .reset                (reset),
        .play_enable          (play_enable),
        .beat                 (beat),
        .generate_next_sample (generate_next_sample),
        .song                 (song.slave),
        .rom_addr             (rom_addr),
        .rom_step             (rom_step),
        .phase                (phase),
        .new_phase_ready      (new_phase_ready),
        .busy                 (busy)
    );

    // frequency_rom model: the DUT's rom_addr register is the address register,
    // so data follows the address within the next cycle.
    assign rom_step = rom_mem[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count note_done pulses seen at each rising edge.
    always @(posedge clk) begin
        if (song.note_done === 1'b1) done_count++;
    end

    task automatic cyc(input logic b, input logic s);
        beat = b;
        generate_next_sample = s;
        @(posedge clk);
        #1;
        beat = 1'b0;
        generate_next_sample = 1'b0;
    endtask

    task automatic load(input logic [5:0] note, input logic [5:0] dur);
        song.load_new_note    = 1'b1;
        song.note_to_load     = note;
        song.duration_to_load = dur;
        @(posedge clk);
        #1;
        song.load_new_note = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({phase, rom_addr, new_phase_ready, busy, song.note_done} !== 31'd0) begin
            errors++;
            $display("FAIL reset_initial: outputs=%h required 0",
                     {phase, rom_addr, new_phase_ready, busy, song.note_done});
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: busy=%b required 0", busy);
        end
        // Load a note so outputs are nonzero, then reset between edges.
        rom_mem[33] = 20'h00777;
        load(6'd33, 6'd2);
        checks++;
        if (busy !== 1'b1 || rom_addr !== 6'd33) begin
            errors++;
            $display("FAIL reset_preload: busy=%b rom_addr=%0d required 1/33", busy, rom_addr);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({phase, rom_addr, new_phase_ready, busy, song.note_done} !== 31'd0) begin
            errors++;
            $display("FAIL reset_async: outputs=%h required 0",
                     {phase, rom_addr, new_phase_ready, busy, song.note_done});
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_note();
        rom_mem[49] = 20'h00ABC;
        load(6'd49, 6'd3);
        checks++;
        if (rom_addr !== 6'd49 || busy !== 1'b1) begin
            errors++;
            $display("FAIL note_load: rom_addr=%0d busy=%b required 49/1", rom_addr, busy);
        end
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        checks++;
        if (phase !== 22'h000ABC || new_phase_ready !== 1'b1) begin
            errors++;
            $display("FAIL note_sample1: phase=%h npr=%b required 000abc/1", phase, new_phase_ready);
        end
        cyc(1'b0, 1'b1);
        checks++;
        if (phase !== 22'h001578) begin
            errors++;
            $display("FAIL note_sample2: phase=%h required 001578", phase);
        end
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        checks++;
        if (song.note_done !== 1'b0 || new_phase_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL note_beat2: done=%b npr=%b busy=%b required 0/0/1",
                     song.note_done, new_phase_ready, busy);
        end
        cyc(1'b1, 1'b0);
        checks++;
        if (song.note_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL note_done_pulse: done=%b busy=%b required 1/0", song.note_done, busy);
        end
        cyc(1'b0, 1'b0);
        checks++;
        if (song.note_done !== 1'b0 || phase !== 22'h001578 || rom_addr !== 6'd49) begin
            errors++;
            $display("FAIL note_after: done=%b phase=%h rom_addr=%0d required 0/001578/49",
                     song.note_done, phase, rom_addr);
        end
    endtask

    task automatic test_rest();
        rom_mem[0] = 20'h12345;
        load(6'd0, 6'd2);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        checks++;
        if (phase !== 22'd0 || new_phase_ready !== 1'b1) begin
            errors++;
            $display("FAIL rest_sample: phase=%h npr=%b required 0/1", phase, new_phase_ready);
        end
        cyc(1'b1, 1'b1);
        checks++;
        if (phase !== 22'd0 || song.note_done !== 1'b0) begin
            errors++;
            $display("FAIL rest_beat1: phase=%h done=%b required 0/0", phase, song.note_done);
        end
        cyc(1'b1, 1'b0);
        checks++;
        if (song.note_done !== 1'b1) begin
            errors++;
            $display("FAIL rest_done: done=%b required 1", song.note_done);
        end
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_zero_duration();
        rom_mem[10] = 20'h00111;
        load(6'd10, 6'd0);
        checks++;
        if (song.note_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_n1: done=%b busy=%b required 0/1", song.note_done, busy);
        end
        cyc(1'b0, 1'b1);
        checks++;
        if (song.note_done !== 1'b1 || busy !== 1'b0 || phase !== 22'd0 || new_phase_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_n2: done=%b busy=%b phase=%h npr=%b required 1/0/0/0",
                     song.note_done, busy, phase, new_phase_ready);
        end
        cyc(1'b0, 1'b0);
        checks++;
        if (song.note_done !== 1'b0) begin
            errors++;
            $display("FAIL zero_n3: done=%b required 0", song.note_done);
        end
    endtask

    task automatic test_wrap_pause();
        int saved_done;
        rom_mem[20] = 20'hFFFFF;
        load(6'd20, 6'd4);
        cyc(1'b0, 1'b0);
        repeat (4) cyc(1'b0, 1'b1);
        checks++;
        if (phase !== 22'h3FFFFC) begin
            errors++;
            $display("FAIL wrap_pre: phase=%h required 3ffffc", phase);
        end
        cyc(1'b1, 1'b1);
        checks++;
        if (phase !== 22'h0FFFFB) begin
            errors++;
            $display("FAIL wrap_post: phase=%h required 0ffffb", phase);
        end
        saved_done = done_count;
        play_enable = 1'b0;
        repeat (5) cyc(1'b1, 1'b1);
        checks++;
        if (phase !== 22'h0FFFFB || busy !== 1'b1 || new_phase_ready !== 1'b0 || done_count != saved_done) begin
            errors++;
            $display("FAIL pause_hold: phase=%h busy=%b npr=%b dones=%0d required 0ffffb/1/0/%0d",
                     phase, busy, new_phase_ready, done_count, saved_done);
        end
        play_enable = 1'b1;
        cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b0);
        checks++;
        if (song.note_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL resume_beat3: done=%b busy=%b required 0/1", song.note_done, busy);
        end
        cyc(1'b1, 1'b0);
        checks++;
        if (song.note_done !== 1'b1) begin
            errors++;
            $display("FAIL resume_done: done=%b required 1", song.note_done);
        end
        cyc(1'b0, 1'b0);
    endtask

    task automatic test_ignore_and_reset();
        int saved_done;
        rom_mem[7] = 20'h00100;
        rom_mem[5] = 20'h00055;
        load(6'd7, 6'd5);
        cyc(1'b0, 1'b0);
        load(6'd5, 6'd2);
        checks++;
        if (rom_addr !== 6'd7 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ignore_load: rom_addr=%0d busy=%b required 7/1", rom_addr, busy);
        end
        cyc(1'b0, 1'b1);
        checks++;
        if (phase !== 22'h000100) begin
            errors++;
            $display("FAIL ignore_step: phase=%h required 000100", phase);
        end
        saved_done = done_count;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({phase, rom_addr, new_phase_ready, busy, song.note_done} !== 31'd0) begin
            errors++;
            $display("FAIL midplay_reset: outputs=%h required 0",
                     {phase, rom_addr, new_phase_ready, busy, song.note_done});
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        repeat (3) cyc(1'b1, 1'b1);
        checks++;
        if (done_count != saved_done || busy !== 1'b0) begin
            errors++;
            $display("FAIL midplay_no_done: dones=%0d busy=%b required %0d/0", done_count, busy, saved_done);
        end
        rom_mem[3] = 20'h00020;
        load(6'd3, 6'd1);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        checks++;
        if (song.note_done !== 1'b1 || phase !== 22'h000020 || rom_addr !== 6'd3) begin
            errors++;
            $display("FAIL after_reset_note: done=%b phase=%h rom_addr=%0d required 1/000020/3",
                     song.note_done, phase, rom_addr);
        end
        cyc(1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done_count = 0;
        for (int i = 0; i < 64; i++) rom_mem[i] = 20'h0;
        reset = 1'b0;
        play_enable = 1'b1;
        beat = 1'b0;
        generate_next_sample = 1'b0;
        song.load_new_note = 1'b0;
        song.note_to_load = 6'd0;
        song.duration_to_load = 6'd0;

        test_reset();
        test_note();
        test_rest();
        test_zero_duration();
        test_wrap_pause();
        test_ignore_and_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
